dec_2_4_buf: RTL and testbench
==============================

DEC_2_4_BUF -- requirements
Module: dec_2_4_buf

Interface
REQ-001 Parameter: CNT_W, default 8, width of each per-line delivery counter (legal range 2..16).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 Port: i  input  2  binary code to decode: 0->y[0], 1->y[1], 2->y[2], 3->y[3].
REQ-005 Port: en  input  1  decode enable, sampled with i on accept; 0 stores an all-zero word.
REQ-006 Port: in_valid  input  1  producer presents i/en.
REQ-007 Port: in_ready  output  1  block can accept; high when FIFO not full.
REQ-008 Port: y  output  4  one-hot decoded word at FIFO head; 4'b0000 when empty.
REQ-009 Port: out_valid  output  1  y holds a valid word (FIFO not empty).
REQ-010 Port: out_ready  input  1  consumer takes y.
REQ-011 Port: level  output  2  FIFO occupancy, 0..2.
REQ-012 Port: cnt_sel  input  2  selects which line counter drives cnt.
REQ-013 Port: cnt  output  CNT_W  delivery count of line cnt_sel (combinational mux of registers).
REQ-014 Port: clr_cnt  input  1  synchronous clear of all four counters.
REQ-015 The design SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-016 Accept SHALL occur on a rising edge where in_valid && in_ready; push word = en ? (4'b0001 << i) : 4'b0000.
REQ-017 Storage SHALL be a 2-entry FIFO (read/write pointers plus count), in order, no reordering.
REQ-018 in_ready SHALL be 1 when level < 2 and 0 when level == 2, derived from registered state only (no combinational path from out_ready).
REQ-019 Pop SHALL occur on a rising edge where out_valid && out_ready.
REQ-020 Latency: a word accepted at edge N into an empty FIFO SHALL appear on y with out_valid=1 after edge N; no same-cycle bypass.
REQ-021 Simultaneous push and pop at level 1 SHALL keep level at 1 and present the older word then the newer word.
REQ-022 At level 2, a pop SHALL not enable a same-edge push (in_ready already 0); level becomes 1.
REQ-023 At level 0, out_ready SHALL be ignored and y SHALL read 4'b0000.
REQ-024 y and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 Pointers SHALL wrap modulo 2.
REQ-026 On each pop, the counter of every bit set in y SHALL increment by 1; an all-zero word increments none.
REQ-027 Counters SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-028 clr_cnt SHALL clear all counters to 0 at the edge and take priority over a same-edge increment.
REQ-029 clr_cnt SHALL not affect FIFO contents, level, or handshakes.

Reset
REQ-030 While rst_n=0: level=0, out_valid=0, y=4'b0000, in_ready=1, all counters=0, pointers=0.
REQ-031 Reset asserted mid-transfer SHALL discard all stored words immediately, without waiting for a clock edge.
REQ-032 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-033 Reset then i=2,en=1,in_valid=1 one cycle, out_ready=0 -> next cycle y=4'b0100, out_valid=1, level=1, in_ready=1.
REQ-034 Push i=0 then i=3 with out_ready=0 -> level=2, in_ready=0; third in_valid ignored; then out_ready=1 -> y=0001 then 1000 on consecutive cycles, then out_valid=0.
REQ-035 level=1 (head 0010), push i=1 while popping -> level stays 1, next y=0010; cnt_sel=1 -> cnt=1.
REQ-036 Push en=0,i=3 and pop -> y=0000, out_valid=1 for that word; all counters unchanged.
REQ-037 CNT_W=2, deliver i=1 five times -> cnt (sel=1)=3 saturated; clr_cnt on the same edge as a line-1 pop -> cnt=0.
REQ-038 level=2, assert rst_n=0 between edges -> out_valid=0, y=0000, in_ready=1, cnt=0 without a clock edge.

Source files
------------

// File: rtl/dec_2_4_buf.sv
// dec_2_4_buf
//   2-to-4 one-hot decoder feeding a 2-entry ready/valid FIFO, with one
//   saturating delivery counter per output line.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   i          binary code to decode (0..3 -> y[0]..y[3])
//   en         decode enable; 0 stores an all-zero word
//   in_valid   producer presents i/en
//   in_ready   FIFO not full
//   y          decoded word at FIFO head, 4'b0000 when empty
//   out_valid  FIFO not empty
//   out_ready  consumer takes y
//   level      FIFO occupancy 0..2
//   cnt_sel    selects which line counter drives cnt
//   cnt        delivery count of line cnt_sel
//   clr_cnt    synchronous clear of all four counters
module dec_2_4_buf #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       level,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt,
  input  logic             clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       mem_q [2];
  logic [3:0]       mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic             push;
  logic             pop;
  logic [3:0]       push_word;

  // Handshake outputs come from registered occupancy only, so in_ready has
  // no combinational dependence on out_ready.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    y         = out_valid ? mem_q[rd_ptr_q] : 4'b0000;
    level     = count_q;
    cnt       = cnt_q[cnt_sel];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    push_word = en ? (4'b0001 << i) : 4'b0000;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Counters credit the word actually leaving (y at the pop edge); a clear
  // on the same edge wins over the increment.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_cnt) begin
        cnt_d[k] = '0;
      end else if (pop && y[k] && (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= 4'b0000;
      mem_q[1] <= 4'b0000;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_dec_2_4_buf.sv
// tb_dec_2_4_buf
//   Drives two instances (default CNT_W and CNT_W=2) with shared inputs and
//   compares both against a queue-based reference model.
module tb_dec_2_4_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i;
  logic       en;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] cnt_sel;
  logic       clr_cnt;

  logic       in_ready_a, out_valid_a;
  logic [3:0] y_a;
  logic [1:0] level_a;
  logic [7:0] cnt_a;

  logic       in_ready_b, out_valid_b;
  logic [3:0] y_b;
  logic [1:0] level_b;
  logic [1:0] cnt_b;

  int tests = 0;
  int fails = 0;

  logic [3:0] mq[$];
  int         mca[4];
  int         mcb[4];

  always #10 clk = ~clk;

  dec_2_4_buf u_dut_a (
    .clk(clk), .rst_n(rst_n), .i(i), .en(en), .in_valid(in_valid),
    .in_ready(in_ready_a), .y(y_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .level(level_a), .cnt_sel(cnt_sel),
    .cnt(cnt_a), .clr_cnt(clr_cnt)
  );

  dec_2_4_buf #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i(i), .en(en), .in_valid(in_valid),
    .in_ready(in_ready_b), .y(y_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .level(level_b), .cnt_sel(cnt_sel),
    .cnt(cnt_b), .clr_cnt(clr_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 4; k++) begin
      mca[k] = 0;
      mcb[k] = 0;
    end
  endtask

  // Called in the low phase of clk; the counter sweep takes 4 ns.
  task automatic check_all(input string tag);
    logic [3:0] ey;
    int         sz;
    sz = mq.size();
    ey = (sz > 0) ? mq[0] : 4'b0000;
    chk({tag, ".level_a"}, 16'(level_a), 16'(sz));
    chk({tag, ".in_ready_a"}, 16'(in_ready_a), 16'(sz < 2));
    chk({tag, ".out_valid_a"}, 16'(out_valid_a), 16'(sz > 0));
    chk({tag, ".y_a"}, 16'(y_a), 16'(ey));
    chk({tag, ".level_b"}, 16'(level_b), 16'(sz));
    chk({tag, ".in_ready_b"}, 16'(in_ready_b), 16'(sz < 2));
    chk({tag, ".out_valid_b"}, 16'(out_valid_b), 16'(sz > 0));
    chk({tag, ".y_b"}, 16'(y_b), 16'(ey));
    for (int k = 0; k < 4; k++) begin
      cnt_sel = 2'(k);
      #1;
      chk($sformatf("%s.cnt_a[%0d]", tag, k), 16'(cnt_a), 16'(mca[k]));
      chk($sformatf("%s.cnt_b[%0d]", tag, k), 16'(cnt_b), 16'(mcb[k]));
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, then check.
  task automatic step(input logic v, input logic [1:0] ii, input logic e,
                      input logic ordy, input logic clr, input string tag);
    logic [3:0] w;
    logic [3:0] pw;
    bit         do_push, do_pop;
    in_valid  = v;
    i         = ii;
    en        = e;
    out_ready = ordy;
    clr_cnt   = clr;
    do_pop  = (mq.size() > 0) && ordy;
    do_push = v && (mq.size() < 2);
    if (do_pop) begin
      w = mq.pop_front();
      for (int k = 0; k < 4; k++) begin
        if (w[k]) begin
          mca[k] = (mca[k] < 255) ? mca[k] + 1 : 255;
          mcb[k] = (mcb[k] < 3) ? mcb[k] + 1 : 3;
        end
      end
    end
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        mca[k] = 0;
        mcb[k] = 0;
      end
    end
    if (do_push) begin
      for (int k = 0; k < 4; k++) pw[k] = e && (int'(ii) == k);
      mq.push_back(pw);
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset asserted in the high phase, checked before any further edge.
  task automatic do_async_rst(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".y_now"}, 16'(y_a), 16'h0);
    chk({tag, ".out_valid_now"}, 16'(out_valid_a), 16'h0);
    check_all(tag);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    i         = 2'd0;
    en        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_sel   = 2'd0;
    clr_cnt   = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First accept right after reset release; one-cycle latency.
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, "r033");
    chk("r033.y_const", 16'(y_a), 16'h4);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, "r033_drain");

    // Fill, ignored third push, then drain in order.
    step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, "r034_p0");
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, "r034_p3");
    chk("r034.in_ready_full", 16'(in_ready_a), 16'h0);
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, "r034_ignored");
    chk("r034.head_hold", 16'(y_a), 16'h1);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, "r034_pop1");
    chk("r034.y_second", 16'(y_a), 16'h8);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, "r034_pop2");
    chk("r034.empty", 16'(out_valid_a), 16'h0);

    // Push while popping at level 1.
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, "r035_fill");
    step(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, "r035_pushpop");
    cnt_sel = 2'd1;
    #1;
    chk("r035.cnt1", 16'(cnt_a), 16'h1);

    // Disabled decode stores and delivers an all-zero word.
    step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, "r036_push0");
    chk("r036.y_zero", 16'(y_a), 16'h0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, "r036_pop0");

    // Saturation in the narrow instance, then clear wins over increment.
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, $sformatf("r037_deliver%0d", n));
    end
    cnt_sel = 2'd1;
    #1;
    chk("r037.cnt_b_sat", 16'(cnt_b), 16'h3);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, "r037_clr_pop");

    // Async reset with a full FIFO.
    step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, "r038_p0");
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, "r038_p2");
    do_async_rst("r038");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_async_rst($sformatf("rnd_rst%0d", n));
      end else begin
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 15) == 0), $sformatf("rnd%0d", n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
